// File: rtl/local_history_table.sv
// local_history_table: per-branch local history table feeding the pc+bh PHT.
// Fetch side returns registered {history, history ^ pc} one cycle after pc_reg
// is sampled; EX side shifts resolved conditional-direct outcomes into the entry.
// After reset and on flush the table walks every entry to zero (ready=0).
// Optional macro LHT_BYPASS_EN: forward a same-cycle update to the read port
// (write-before-read); undefined gives read-before-write.
// Handshake: ready=1 means reads return real history and updates are accepted;
// while ready=0 reads return 0 and updates are silently dropped.
module local_history_table #(
    parameter int H_WIDTH    = 8,
    parameter int IDX_WIDTH  = 6,
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    output logic                  ready,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] pc_reg,
    output logic [H_WIDTH-1:0]    pc_bh_hashed,
    output logic [H_WIDTH-1:0]    bh_out,
    input  logic                  update_en,
    input  logic [2:0]            kind_ex,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  taken_real,
    output logic                  dbg_state
);

    localparam int N_ENTRIES = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] CNT_LAST    = {IDX_WIDTH{1'b1}};
    localparam logic [2:0]           KIND_DIRECT = 3'd1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [H_WIDTH-1:0]   mem_q [N_ENTRIES];
    logic [H_WIDTH-1:0]   bh_q, bh_d;
    logic [H_WIDTH-1:0]   hash_q, hash_d;

    logic                 clear_we;
    logic                 upd_fire;
    logic [IDX_WIDTH-1:0] upd_idx;
    logic [IDX_WIDTH-1:0] rd_idx;
    logic [H_WIDTH-1:0]   upd_val;
    logic [H_WIDTH-1:0]   rd_hist;

    // Upper PC bits are irrelevant: entries alias on the low index bits, no tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_reg[ADDR_WIDTH-1:H_WIDTH], pc_ex[ADDR_WIDTH-1:IDX_WIDTH]};

    assign upd_idx  = pc_ex[IDX_WIDTH-1:0];
    assign rd_idx   = pc_reg[IDX_WIDTH-1:0];
    assign upd_val  = {mem_q[upd_idx][H_WIDTH-2:0], taken_real};
    // Flush beats a same-cycle update; CLEAR drops updates (including its last cycle).
    assign upd_fire = (state_q == ST_RUN) && update_en && (kind_ex == KIND_DIRECT) && !flush;

    assign ready        = (state_q == ST_RUN);
    assign dbg_state    = state_q;
    assign bh_out       = bh_q;
    assign pc_bh_hashed = hash_q;

    // Clear-walk sequencing: CLEAR zeroes one entry per cycle, flush restarts it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
                if (flush) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and clear counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // History storage: no reset, the clear walk zeroes it.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[cnt_q] <= '0;
        end else if (upd_fire) begin
            mem_q[upd_idx] <= upd_val;
        end
    end

    // Fetch read path and next values of the output registers.
    always_comb begin
        rd_hist = mem_q[rd_idx];
`ifdef LHT_BYPASS_EN
        if (upd_fire && (upd_idx == rd_idx)) begin
            rd_hist = upd_val;
        end
`endif
        bh_d   = bh_q;
        hash_d = hash_q;
        if (!stall) begin
            if (state_q == ST_CLEAR) begin
                bh_d   = '0;
                hash_d = '0;
            end else begin
                bh_d   = rd_hist;
                hash_d = rd_hist ^ pc_reg[H_WIDTH-1:0];
            end
        end
    end

    // Fetch-side output registers (held while stall=1).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bh_q   <= '0;
            hash_q <= '0;
        end else begin
            bh_q   <= bh_d;
            hash_q <= hash_d;
        end
    end

endmodule

// File: tb/tb_local_history_table.sv
// tb_local_history_table: scoreboard bench for local_history_table.
// Honours LHT_BYPASS_EN the same way as the design build.
module tb_local_history_table;

    localparam int HW   = 8;
    localparam int IW   = 6;
    localparam int AW   = 30;
    localparam int NENT = 2 ** IW;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          ready;
    logic          stall;
    logic [AW-1:0] pc_reg;
    logic [HW-1:0] pc_bh_hashed;
    logic [HW-1:0] bh_out;
    logic          update_en;
    logic [2:0]    kind_ex;
    logic [AW-1:0] pc_ex;
    logic          taken_real;
    logic          dbg_state;

    logic [HW-1:0]   model_mem [NENT];
    logic [2*HW-1:0] exp_q [$];
    logic [2*HW-1:0] last_exp;
    int              clear_left;
    int              vectors;
    int              miscompares;

    local_history_table #(
        .H_WIDTH   (HW),
        .IDX_WIDTH (IW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .ready       (ready),
        .stall       (stall),
        .pc_reg      (pc_reg),
        .pc_bh_hashed(pc_bh_hashed),
        .bh_out      (bh_out),
        .update_en   (update_en),
        .kind_ex     (kind_ex),
        .pc_ex       (pc_ex),
        .taken_real  (taken_real),
        .dbg_state   (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: one RUN-state cycle; pushes the expected {bh_out, pc_bh_hashed}.
    task automatic drive(input logic [AW-1:0] pc_rd, input logic st, input logic ue,
                         input logic [2:0] k, input logic [AW-1:0] pcx,
                         input logic tk, input logic fl);
        logic [HW-1:0]   h;
        logic [HW-1:0]   nv;
        logic            fire;
        logic [2*HW-1:0] e;
        fire = ue && (k == 3'd1) && !fl;
        h    = model_mem[pc_rd[IW-1:0]];
        nv   = {model_mem[pcx[IW-1:0]][HW-2:0], tk};
`ifdef LHT_BYPASS_EN
        if (fire && (pcx[IW-1:0] == pc_rd[IW-1:0])) h = nv;
`endif
        e = st ? last_exp : {h, h ^ pc_rd[HW-1:0]};
        last_exp = e;
        exp_q.push_back(e);
        pc_reg = pc_rd; stall = st; update_en = ue; kind_ex = k;
        pc_ex = pcx; taken_real = tk; flush = fl;
        @(posedge clk); #1;
        if (fire) model_mem[pcx[IW-1:0]] = nv;
        if (fl) begin
            for (int i = 0; i < NENT; i++) model_mem[i] = '0;
            clear_left = NENT;
        end
        update_en = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; stall = 1'b0; pc_reg = '0; update_en = 1'b0;
        kind_ex = 3'd0; pc_ex = '0; taken_real = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b0 || {bh_out, pc_bh_hashed} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b bh=%h hash=%h, expected ready=0 bh=00 hash=00",
                     ready, bh_out, pc_bh_hashed);
        end
        rstn = 1'b1;
        clear_left = NENT;
        last_exp = '0;
        for (int i = 0; i < NENT; i++) model_mem[i] = '0;
        for (int i = 0; i < NENT + 4; i++) begin
            vectors++;
            if (ready !== (clear_left == 0) || dbg_state !== (clear_left == 0)) begin
                miscompares++;
                $display("FAIL reset_ready cycle %0d: ready=%b state=%b, expected %b",
                         i, ready, dbg_state, (clear_left == 0));
            end
            vectors++;
            if ({bh_out, pc_bh_hashed} !== '0) begin
                miscompares++;
                $display("FAIL reset_clear_out cycle %0d: bh=%h hash=%h, expected 00/00",
                         i, bh_out, pc_bh_hashed);
            end
            if (clear_left > 0) begin
                pc_reg = AW'($urandom); pc_ex = AW'($urandom);
                update_en = 1'($urandom_range(0, 1)); kind_ex = 3'd1; taken_real = 1'b1;
            end else begin
                pc_reg = '0; update_en = 1'b0;
            end
            @(posedge clk); #1;
            if (clear_left > 0) clear_left--;
        end
        update_en = 1'b0;
    endtask

    task automatic test_non_direct_kinds();
        logic [2:0]      kinds [7];
        logic [2*HW-1:0] e;
        kinds = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd2, 3'd3};
        for (int i = 0; i < 7; i++) begin
            drive(AW'(32'h20), 1'b0, 1'b1, kinds[i], AW'(32'h10), 1'b1, 1'b0);
            e = exp_q.pop_front();
            vectors++;
            if ({bh_out, pc_bh_hashed} !== e) begin
                miscompares++;
                $display("FAIL kinds_side_read kind=%0d: got %h, expected %h",
                         kinds[i], {bh_out, pc_bh_hashed}, e);
            end
        end
        // update_en low with a direct kind must not write either
        drive(AW'(32'h20), 1'b0, 1'b0, 3'd1, AW'(32'h10), 1'b1, 1'b0);
        e = exp_q.pop_front();
        drive(AW'(32'h10), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL kinds_no_write: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
    endtask

    task automatic test_direct_updates();
        logic [2*HW-1:0] e;
        logic            outcomes [3];
        outcomes = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(AW'(32'h30), 1'b0, 1'b1, 3'd1, AW'(32'h10), outcomes[i], 1'b0);
            e = exp_q.pop_front();
            vectors++;
            if ({bh_out, pc_bh_hashed} !== e) begin
                miscompares++;
                $display("FAIL direct_side_read %0d: got %h, expected %h", i, {bh_out, pc_bh_hashed}, e);
            end
        end
        drive(AW'(32'h10), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL direct_read_0x10: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
        // 0x50 aliases entry 0x10 but hashes with its own low PC bits
        drive(AW'(32'h50), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL direct_alias_0x50: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
    endtask

    task automatic test_same_cycle();
        logic [2*HW-1:0] e;
        drive(AW'(32'h10), 1'b0, 1'b1, 3'd1, AW'(32'h10), 1'b1, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL same_cycle_read: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
        drive(AW'(32'h10), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL same_cycle_next_read: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
    endtask

    task automatic test_stall();
        logic [2*HW-1:0] e;
        drive(AW'(32'h10), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            // an update during stall still lands in the table
            drive(AW'(32'h10 + i), 1'b1, (i == 0), 3'd1, AW'(32'h12), 1'b1, 1'b0);
            e = exp_q.pop_front();
            vectors++;
            if ({bh_out, pc_bh_hashed} !== e) begin
                miscompares++;
                $display("FAIL stall_hold %0d: got %h, expected %h", i, {bh_out, pc_bh_hashed}, e);
            end
        end
        drive(AW'(32'h12), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL stall_release: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
    endtask

    task automatic test_flush();
        logic [2*HW-1:0] e;
        drive(AW'(32'h10), 1'b0, 1'b1, 3'd1, AW'(32'h10), 1'b1, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL flush_cycle_read: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
        for (int i = 0; i < 90; i++) begin
            vectors++;
            if (ready !== (clear_left == 0) || dbg_state !== (clear_left == 0)) begin
                miscompares++;
                $display("FAIL flush_ready cycle %0d: ready=%b state=%b, expected %b",
                         i, ready, dbg_state, (clear_left == 0));
            end
            if (i > 0) begin
                vectors++;
                if ({bh_out, pc_bh_hashed} !== '0) begin
                    miscompares++;
                    $display("FAIL flush_clear_out cycle %0d: bh=%h hash=%h, expected 00/00",
                             i, bh_out, pc_bh_hashed);
                end
            end
            if (clear_left > 0) begin
                pc_reg = AW'($urandom); pc_ex = AW'($urandom);
                update_en = 1'($urandom_range(0, 1)); kind_ex = 3'd1; taken_real = 1'b1;
            end else begin
                pc_reg = '0; update_en = 1'b0;
            end
            flush = (i == 20);
            @(posedge clk); #1;
            if (i == 20) clear_left = NENT;
            else if (clear_left > 0) clear_left--;
            flush = 1'b0;
        end
        update_en = 1'b0;
        last_exp = '0;
        drive(AW'(32'h10), 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({bh_out, pc_bh_hashed} !== e) begin
            miscompares++;
            $display("FAIL flush_dropped_update: got %h, expected %h", {bh_out, pc_bh_hashed}, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*HW-1:0] e;
        logic [AW-1:0]   pr;
        logic [AW-1:0]   px;
        for (int i = 0; i < 300; i++) begin
            pr = AW'($urandom);
            pr[IW-1:0] = IW'(16 + $urandom_range(0, 3));
            px = AW'($urandom);
            px[IW-1:0] = IW'(16 + $urandom_range(0, 3));
            drive(pr, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), px, 1'($urandom_range(0, 1)), 1'b0);
            e = exp_q.pop_front();
            vectors++;
            if ({bh_out, pc_bh_hashed} !== e) begin
                miscompares++;
                $display("FAIL back_to_back %0d: got %h, expected %h", i, {bh_out, pc_bh_hashed}, e);
            end
        end
    endtask

    // Test sequence and final report.
    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_non_direct_kinds();
        test_direct_updates();
        test_same_cycle();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
